// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared types and constants for the snake movement datapath.
//   dir_t       : movement direction of the snake head
//   is_reverse  : true when direction b points straight back against a
//   DEF_GRID_W/H: default playfield size in cells
// ---------------------------------------------------------------------------
package snake_pkg;

   localparam int DEF_GRID_W = 32;
   localparam int DEF_GRID_H = 24;

   typedef enum logic [1:0] {
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   function automatic logic is_reverse(input dir_t a, input dir_t b);
      case (a)
         DIR_UP:    return (b == DIR_DOWN);
         DIR_DOWN:  return (b == DIR_UP);
         DIR_LEFT:  return (b == DIR_RIGHT);
         DIR_RIGHT: return (b == DIR_LEFT);
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// ---------------------------------------------------------------------------
// snake_tick_gen
// Movement-rate divider. Produces a one-cycle step strobe every DIV enabled
// cycles, where DIV depends on the difficulty level.
//   clk          : system clock
//   rst          : asynchronous reset, active-high
//   i_clr        : synchronous clear of the count (game restart)
//   i_en         : count enable; the count holds while low
//   i_difficulty : 0 = NORMAL_DIV, 1 = HARD_DIV
//   o_step       : combinational step strobe, valid in the cycle it fires
// ---------------------------------------------------------------------------
module snake_tick_gen #(
   parameter int NORMAL_DIV = 12500000,
   parameter int HARD_DIV   = 6250000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_difficulty,
   output logic o_step
);

   localparam int MAX_DIV = (NORMAL_DIV > HARD_DIV) ? NORMAL_DIV : HARD_DIV;
   localparam int CW      = $clog2(MAX_DIV + 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_limit;

   assign w_limit = i_difficulty ? CW'(HARD_DIV - 1) : CW'(NORMAL_DIV - 1);

   // ">=" rather than "==": a switch to the faster rate while the count is
   // already past the new limit fires on the next enabled cycle.
   assign o_step = i_en && (r_cnt >= w_limit);

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (o_step) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/snake_engine.sv
// ---------------------------------------------------------------------------
// snake_engine
// Snake movement and collision datapath. Moves the snake one cell per step,
// detects wall/self hits and food, and answers renderer occupancy queries.
//   clk, rst                 : clock, asynchronous active-high reset
//   i_init                   : one-cycle restart pulse (priority over all)
//   i_run                    : level, snake may move
//   i_difficulty             : 0 = normal rate, 1 = hard rate
//   i_btn_{up,down,left,right}_n : active-low direction buttons
//   i_food_x/y               : food cell
//   i_qry_x/y                : renderer query cell
//   o_occupied               : combinational, query cell holds a live segment
//   o_head_x/y               : registered head position
//   o_length                 : live segment count
//   o_food_collision         : one-cycle pulse after eating
//   o_game_over              : sticky wall/self hit flag
// ---------------------------------------------------------------------------
module snake_engine
   import snake_pkg::*;
#(
   parameter int GRID_W     = DEF_GRID_W,
   parameter int GRID_H     = DEF_GRID_H,
   parameter int MAX_LEN    = 32,
   parameter int INIT_LEN   = 3,
   parameter int NORMAL_DIV = 12500000,
   parameter int HARD_DIV   = 6250000,
   localparam int XW        = $clog2(GRID_W),
   localparam int YW        = $clog2(GRID_H),
   localparam int LW        = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_init,
   input  logic          i_run,
   input  logic          i_difficulty,
   input  logic          i_btn_up_n,
   input  logic          i_btn_down_n,
   input  logic          i_btn_left_n,
   input  logic          i_btn_right_n,
   input  logic [XW-1:0] i_food_x,
   input  logic [YW-1:0] i_food_y,
   input  logic [XW-1:0] i_qry_x,
   input  logic [YW-1:0] i_qry_y,
   output logic          o_occupied,
   output logic [XW-1:0] o_head_x,
   output logic [YW-1:0] o_head_y,
   output logic [LW-1:0] o_length,
   output logic          o_food_collision,
   output logic          o_game_over
);

   // Start layout: horizontal line ending at the grid centre, head rightmost.
   function automatic logic [XW-1:0] init_x(input int idx);
      return (idx < INIT_LEN) ? XW'(GRID_W / 2 - idx) : '0;
   endfunction

   logic [XW-1:0] r_seg_x [MAX_LEN];
   logic [YW-1:0] r_seg_y [MAX_LEN];
   logic [LW-1:0] r_length;
   dir_t          r_dir;
   dir_t          r_pending_dir;
   logic          r_food_collision;
   logic          r_game_over;

   logic          w_step;
   logic          w_btn_any;
   dir_t          w_req_dir;
   logic          w_req_ok;
   logic [XW-1:0] w_next_x;
   logic [YW-1:0] w_next_y;
   logic          w_hit_wall;
   logic          w_hit_self;
   logic          w_eat;
   logic          w_move;

   snake_tick_gen #(
      .NORMAL_DIV (NORMAL_DIV),
      .HARD_DIV   (HARD_DIV)
   ) u_tick (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (i_init),
      .i_en         (i_run && !r_game_over),
      .i_difficulty (i_difficulty),
      .o_step       (w_step)
   );

   // Button arbitration: up > down > left > right; reversals are dropped.
   // NOTE: every signal driven in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_btn_any = 1'b1;
      w_req_dir = DIR_RIGHT;
      if (!i_btn_up_n)         w_req_dir = DIR_UP;
      else if (!i_btn_down_n)  w_req_dir = DIR_DOWN;
      else if (!i_btn_left_n)  w_req_dir = DIR_LEFT;
      else if (!i_btn_right_n) w_req_dir = DIR_RIGHT;
      else                     w_btn_any = 1'b0;
      w_req_ok = w_btn_any && !is_reverse(r_dir, w_req_dir);
   end

   // Next head follows the direction being committed on this step.
   always_comb begin
      w_next_x   = r_seg_x[0];
      w_next_y   = r_seg_y[0];
      w_hit_wall = 1'b0;
      case (r_pending_dir)
         DIR_UP:
            if (r_seg_y[0] == '0) w_hit_wall = 1'b1;
            else                  w_next_y   = r_seg_y[0] - YW'(1);
         DIR_DOWN:
            if (r_seg_y[0] == YW'(GRID_H - 1)) w_hit_wall = 1'b1;
            else                               w_next_y   = r_seg_y[0] + YW'(1);
         DIR_LEFT:
            if (r_seg_x[0] == '0) w_hit_wall = 1'b1;
            else                  w_next_x   = r_seg_x[0] - XW'(1);
         default:
            if (r_seg_x[0] == XW'(GRID_W - 1)) w_hit_wall = 1'b1;
            else                               w_next_x   = r_seg_x[0] + XW'(1);
      endcase
   end

   // Self hit checks seg[0..length-2]; the tail cell vacates on the move.
   always_comb begin
      w_hit_self = 1'b0;
      for (int i = 0; i < MAX_LEN - 1; i++) begin
         if ((LW'(i + 1) < r_length) &&
             (r_seg_x[i] == w_next_x) && (r_seg_y[i] == w_next_y))
            w_hit_self = 1'b1;
      end
   end

   assign w_eat  = (w_next_x == i_food_x) && (w_next_y == i_food_y);
   assign w_move = w_step && !w_hit_wall && !w_hit_self;

   always_comb begin
      o_occupied = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((LW'(i) < r_length) &&
             (r_seg_x[i] == i_qry_x) && (r_seg_y[i] == i_qry_y))
            o_occupied = 1'b1;
      end
   end

   // Segment shift register. Entries beyond the live length are don't-care
   // but still shift, which keeps the tail when the snake grows.
   // NOTE: the segment array is reset because the start layout is part of
   // the visible reset state, not just scratch storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            r_seg_x[i] <= init_x(i);
            r_seg_y[i] <= YW'(GRID_H / 2);
         end
      end else if (i_init) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            r_seg_x[i] <= init_x(i);
            r_seg_y[i] <= YW'(GRID_H / 2);
         end
      end else if (w_move) begin
         for (int i = MAX_LEN - 1; i > 0; i--) begin
            r_seg_x[i] <= r_seg_x[i-1];
            r_seg_y[i] <= r_seg_y[i-1];
         end
         r_seg_x[0] <= w_next_x;
         r_seg_y[0] <= w_next_y;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_length         <= LW'(INIT_LEN);
         r_dir            <= DIR_RIGHT;
         r_pending_dir    <= DIR_RIGHT;
         r_food_collision <= 1'b0;
         r_game_over      <= 1'b0;
      end else if (i_init) begin
         r_length         <= LW'(INIT_LEN);
         r_dir            <= DIR_RIGHT;
         r_pending_dir    <= DIR_RIGHT;
         r_food_collision <= 1'b0;
         r_game_over      <= 1'b0;
      end else begin
         r_food_collision <= 1'b0;
         if (w_req_ok) r_pending_dir <= w_req_dir;
         if (w_step) begin
            r_dir <= r_pending_dir;
            if (w_hit_wall || w_hit_self) begin
               r_game_over <= 1'b1;
            end else if (w_eat) begin
               r_food_collision <= 1'b1;
               if (r_length < LW'(MAX_LEN)) r_length <= r_length + LW'(1);
            end
         end
      end
   end

   assign o_head_x         = r_seg_x[0];
   assign o_head_y         = r_seg_y[0];
   assign o_length         = r_length;
   assign o_food_collision = r_food_collision;
   assign o_game_over      = r_game_over;

endmodule

// File: tb/tb_snake_engine.sv
// ---------------------------------------------------------------------------
// tb_snake_engine
// Self-checking bench for snake_engine on an 8x8 grid, MAX_LEN 6, INIT_LEN 3,
// NORMAL_DIV 4, HARD_DIV 2. A queue-based reference model of the game rules
// advances alongside the DUT on every clock edge.
// ---------------------------------------------------------------------------
module tb_snake_engine;

   localparam int GW = 8;
   localparam int GH = 8;
   localparam int ML = 6;
   localparam int IL = 3;
   localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       init, run, diff;
   logic       bu, bd, bl, br;
   logic [2:0] fx, fy, qx, qy;
   logic       occ, fc, go;
   logic [2:0] hx, hy, len;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: body cells as queues, head at index 0
   int m_x[$];
   int m_y[$];
   int m_len, m_dir, m_pend, m_cnt;
   bit m_go, m_fc, m_stepped;

   typedef struct {
      int       n;
      bit       init;
      bit       run;
      bit       diff;
      bit [3:0] btn_n;   // {up, down, left, right}
      int       fx, fy;
      int       ex, ey, elen;
      bit       efc, ego;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   snake_engine #(
      .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL),
      .NORMAL_DIV(4), .HARD_DIV(2)
   ) dut (
      .clk(clk), .rst(rst), .i_init(init), .i_run(run), .i_difficulty(diff),
      .i_btn_up_n(bu), .i_btn_down_n(bd), .i_btn_left_n(bl), .i_btn_right_n(br),
      .i_food_x(fx), .i_food_y(fy), .i_qry_x(qx), .i_qry_y(qy),
      .o_occupied(occ), .o_head_x(hx), .o_head_y(hy), .o_length(len),
      .o_food_collision(fc), .o_game_over(go)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int opposite(input int d);
      case (d)
         UP:      return DOWN;
         DOWN:    return UP;
         LEFT:    return RIGHT;
         default: return LEFT;
      endcase
   endfunction

   task automatic model_reset();
      m_x.delete();
      m_y.delete();
      for (int i = 0; i < IL; i++) begin
         m_x.push_back(GW / 2 - i);
         m_y.push_back(GH / 2);
      end
      m_len = IL; m_dir = RIGHT; m_pend = RIGHT; m_cnt = 0;
      m_go = 0; m_fc = 0;
   endtask

   // Applies the game rules for one clock edge using the current inputs.
   task automatic model_edge();
      int div, nx, ny, req, old_dir, old_pend;
      bit en, step, hit;
      m_stepped = 0;
      if (init) begin
         model_reset();
         return;
      end
      old_dir  = m_dir;
      old_pend = m_pend;
      div  = diff ? 2 : 4;
      en   = run && !m_go;
      step = en && (m_cnt >= div - 1);
      if (en) m_cnt = step ? 0 : m_cnt + 1;
      req = -1;
      if (!bu)      req = UP;
      else if (!bd) req = DOWN;
      else if (!bl) req = LEFT;
      else if (!br) req = RIGHT;
      m_fc = 0;
      if (step) begin
         m_stepped = 1;
         nx = m_x[0] + ((old_pend == RIGHT) ? 1 : 0) - ((old_pend == LEFT) ? 1 : 0);
         ny = m_y[0] + ((old_pend == DOWN) ? 1 : 0) - ((old_pend == UP) ? 1 : 0);
         hit = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
         if (!hit)
            for (int j = 0; j < m_len - 1; j++)
               if (m_x[j] == nx && m_y[j] == ny) hit = 1;
         if (hit) begin
            m_go = 1;
         end else begin
            m_x.push_front(nx);
            m_y.push_front(ny);
            if (nx == int'(fx) && ny == int'(fy)) begin
               m_fc = 1;
               if (m_len < ML) m_len++;
            end
            while (m_x.size() > m_len) begin
               void'(m_x.pop_back());
               void'(m_y.pop_back());
            end
         end
         m_dir = old_pend;
      end
      if (req >= 0 && req != opposite(old_dir)) m_pend = req;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init();
      init = 1'b1;
      tick();
      init = 1'b0;
   endtask

   // Advances until the model sees a step, bounded to a few periods.
   task automatic step_once();
      bit seen = 0;
      for (int k = 0; k < 16 && !seen; k++) begin
         tick();
         seen = m_stepped;
      end
      if (!seen) check("step_timeout", 0, 1);
   endtask

   task automatic check_model(input string tag);
      bit exp_occ;
      check({tag, "_head_x"}, int'(hx), m_x[0]);
      check({tag, "_head_y"}, int'(hy), m_y[0]);
      check({tag, "_length"}, int'(len), m_len);
      check({tag, "_food"}, int'(fc), int'(m_fc));
      check({tag, "_game_over"}, int'(go), int'(m_go));
      qx = 3'($urandom_range(0, GW - 1));
      qy = 3'($urandom_range(0, GH - 1));
      #1;
      exp_occ = 0;
      for (int j = 0; j < m_len; j++)
         if (m_x[j] == int'(qx) && m_y[j] == int'(qy)) exp_occ = 1;
      check({tag, "_occupied"}, int'(occ), int'(exp_occ));
   endtask

   task automatic check_pos(input string tag, input int ex, input int ey,
                            input int elen, input int ego);
      check({tag, "_head_x"}, int'(hx), ex);
      check({tag, "_head_y"}, int'(hy), ey);
      check({tag, "_length"}, int'(len), elen);
      check({tag, "_game_over"}, int'(go), ego);
   endtask

   task automatic check_occ(input string tag, input int x, input int y, input int exp);
      qx = 3'(x);
      qy = 3'(y);
      #1;
      check(tag, int'(occ), exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; init = 1'b0; run = 1'b0; diff = 1'b0;
      bu = 1'b1; bd = 1'b1; bl = 1'b1; br = 1'b1;
      fx = 3'd7; fy = 3'd7; qx = 3'd0; qy = 3'd0;
      model_reset();
      #2;
      check_pos("reset", 4, 4, 3, 0);
      check("reset_food", int'(fc), 0);
      check_occ("reset_occ_tail", 2, 4, 1);
      check_occ("reset_occ_free", 1, 4, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ---- table-driven: straight run into the wall, then eat after init
      vecs.push_back('{3,  0, 1, 0, 4'hF, 7, 7, 4, 4, 3, 0, 0});
      vecs.push_back('{1,  0, 1, 0, 4'hF, 7, 7, 5, 4, 3, 0, 0});
      vecs.push_back('{4,  0, 1, 0, 4'hF, 7, 7, 6, 4, 3, 0, 0});
      vecs.push_back('{4,  0, 1, 0, 4'hF, 7, 7, 7, 4, 3, 0, 0});
      vecs.push_back('{4,  0, 1, 0, 4'hF, 7, 7, 7, 4, 3, 0, 1});
      vecs.push_back('{10, 0, 1, 0, 4'hF, 7, 7, 7, 4, 3, 0, 1});
      vecs.push_back('{1,  1, 1, 0, 4'hF, 5, 4, 4, 4, 3, 0, 0});
      vecs.push_back('{3,  0, 1, 0, 4'hF, 5, 4, 4, 4, 3, 0, 0});
      vecs.push_back('{1,  0, 1, 0, 4'hF, 5, 4, 5, 4, 4, 1, 0});
      vecs.push_back('{1,  0, 1, 0, 4'hF, 5, 4, 5, 4, 4, 0, 0});
      for (int v = 0; v < vecs.size(); v++) begin
         init = vecs[v].init; run = vecs[v].run; diff = vecs[v].diff;
         {bu, bd, bl, br} = vecs[v].btn_n;
         fx = 3'(vecs[v].fx); fy = 3'(vecs[v].fy);
         for (int k = 0; k < vecs[v].n; k++) tick();
         init = 1'b0;
         check_pos($sformatf("vec%0d", v), vecs[v].ex, vecs[v].ey,
                   vecs[v].elen, int'(vecs[v].ego));
         check($sformatf("vec%0d_food", v), int'(fc), int'(vecs[v].efc));
      end
      check_occ("grow_tail_kept", 2, 4, 1);
      check_occ("grow_beyond_tail", 1, 4, 0);

      // ---- direction capture: reversal ignored, latest valid request wins
      fx = 3'd0; fy = 3'd0;
      do_init();
      bl = 1'b0; tick(); bl = 1'b1;
      bu = 1'b0; tick(); bu = 1'b1;
      br = 1'b0; tick(); br = 1'b1;
      step_once();
      check_pos("dir_latest", 5, 4, 3, 0);
      do_init();
      bu = 1'b0; bl = 1'b0;
      step_once();
      bu = 1'b1; bl = 1'b1;
      check_pos("dir_priority", 4, 3, 3, 0);

      // ---- difficulty: hard rate and a mid-count switch
      do_init();
      diff = 1'b1;
      tick(); tick();
      check_pos("hard_step1", 5, 4, 3, 0);
      tick(); tick();
      check_pos("hard_step2", 6, 4, 3, 0);
      diff = 1'b0;
      do_init();
      tick(); tick();
      diff = 1'b1;
      tick();
      check_pos("mid_switch", 5, 4, 3, 0);
      diff = 1'b0;

      // ---- U-turn into own body at length 5
      do_init();
      fx = 3'd5; fy = 3'd4; step_once();
      fx = 3'd6; fy = 3'd4; step_once();
      check_pos("grow_to5", 6, 4, 5, 0);
      fx = 3'd0; fy = 3'd0;
      bu = 1'b0; step_once(); bu = 1'b1;
      bl = 1'b0; step_once(); bl = 1'b1;
      bd = 1'b0; step_once(); bd = 1'b1;
      check_pos("self_hit", 5, 3, 5, 1);
      check("self_hit_no_food", int'(fc), 0);

      // ---- stepping into the vacating tail of a length-4 loop
      do_init();
      fx = 3'd5; fy = 3'd4; step_once();
      fx = 3'd0; fy = 3'd0;
      bu = 1'b0; step_once(); bu = 1'b1;
      bl = 1'b0; step_once(); bl = 1'b1;
      bd = 1'b0; step_once(); bd = 1'b1;
      check_pos("tail_legal", 4, 4, 4, 0);

      // ---- init after game over, then run=0 holds the count
      do_init();
      diff = 1'b1;
      repeat (4) step_once();
      check_pos("hard_wall", 7, 4, 3, 1);
      diff = 1'b0;
      tick(); tick(); tick();
      do_init();
      check_pos("init_clear", 4, 4, 3, 0);
      tick(); tick();
      run = 1'b0;
      repeat (10) tick();
      check_pos("run_low_hold", 4, 4, 3, 0);
      run = 1'b1;
      tick();
      check_pos("resume_cnt3", 4, 4, 3, 0);
      tick();
      check_pos("resume_step", 5, 4, 3, 0);
      check_model("directed_end");

      // ---- randomized against the reference model
      do_init();
      for (int c = 0; c < 3000; c++) begin
         init = ($urandom_range(0, 59) == 0);
         run  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) diff = ~diff;
         bu = ($urandom_range(0, 7) != 0);
         bd = ($urandom_range(0, 7) != 0);
         bl = ($urandom_range(0, 7) != 0);
         br = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 19) == 0) begin
            fx = 3'($urandom_range(0, GW - 1));
            fy = 3'($urandom_range(0, GH - 1));
         end
         tick();
         check_model("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
